down_counter_timer: RTL and testbench

- Loadable down-counter/timer; the count-down counterpart to the free-running up counter in the lab datapath.
- Takes a start value, decrements at a prescaled rate while enabled, and raises a one-cycle terminal-count pulse on reaching zero.
- Drives LEDs/7-seg countdown displays and serves as a timeout source for other lab blocks; runs on the 100 MHz board clock.

---
 rtl/down_counter_pkg.sv | 21 ++
 rtl/tick_gen.sv | 49 ++++
 rtl/down_counter_timer.sv | 119 +++++++++++
 tb/tb_down_counter_timer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/down_counter_pkg.sv
// Shared types and helpers for the down_counter_timer block.
//
// Contents:
//   state_e          - FSM state encoding (IDLE, RUN, HOLD, DONE)
//   prescale_width() - prescaler register width for a given PRESCALE
//                      (clog2 of PRESCALE, never less than 1 bit)
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    // PRESCALE=1 still needs a 1-bit register so the counter is never zero-width.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescale tick generator: counts enabled cycles 0..PRESCALE-1 and flags the
// last one. Also used as the 7-seg refresh divider.
//
// Parameters:
//   PRESCALE - clock cycles per tick (>= 1)
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   clr  in   synchronous clear of the prescaler (wins over run)
//   run  in   advance the prescaler this cycle
//   tick out  high in the run cycle where the prescaler sits at PRESCALE-1
module tick_gen
    import down_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    always_comb begin
        tick = run && (pre_q == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (clr) begin
            pre_q <= '0;
        end else if (run) begin
            // Wrap on the tick; with PRESCALE=1 every run cycle wraps.
            if (tick) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with prescaled decrement and a one-cycle
// terminal-count pulse on reaching zero.
//
// Optional feature macro: DOWN_COUNTER_AUTO_RELOAD_EN
//   defined   - the last load value is kept and reloaded on expiry, giving a
//               periodic tc while the timer stays in RUN
//   undefined - one-shot: expiry parks the timer in DONE until the next load
//
// Parameters:
//   WIDTH    - count / load value width
//   PRESCALE - clock cycles per decrement (>= 1)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   En       in   count enable; low freezes count and prescaler
//   load     in   synchronous load strobe (highest priority after rst)
//   load_val in   start value captured on load
//   cnt      out  current count (registered)
//   tc       out  terminal-count pulse, one cycle
//   busy     out  high in RUN or HOLD (registered)
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy
);

    state_e state_q;
    logic   counting;
    logic   run;
    logic   tick;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    // HOLD counts as soon as En returns, so every enabled cycle advances time.
    always_comb begin
        counting = (state_q == RUN) || (state_q == HOLD);
        run      = counting && En && !load;
    end

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .run (run),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            tc      <= 1'b0;
            busy    <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            tc <= 1'b0;
            if (load) begin
                // Load overrides any decrement or expiry in flight this cycle.
                cnt <= load_val;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                reload_q <= load_val;
`endif
                if (load_val == '0) begin
                    state_q <= DONE;
                    busy    <= 1'b0;
                    tc      <= 1'b1;
                end else begin
                    state_q <= En ? RUN : HOLD;
                    busy    <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    RUN, HOLD: begin
                        if (!En) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= RUN;
                            if (tick) begin
                                if (cnt == WIDTH'(1)) begin
                                    tc <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                                    cnt <= reload_q;
`else
                                    cnt     <= '0;
                                    state_q <= DONE;
                                    busy    <= 1'b0;
`endif
                                end else begin
                                    cnt <= cnt - WIDTH'(1);
                                end
                            end
                        end
                    end
                    IDLE, DONE: begin
                        // Parked until the next load.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       En = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] cnt, cnt4;
    logic       tc, tc4, busy, busy4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .En(En), .load(load), .load_val(load_val),
        .cnt(cnt), .tc(tc), .busy(busy)
    );

    down_counter_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .En(En), .load(load), .load_val(load_val),
        .cnt(cnt4), .tc(tc4), .busy(busy4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({cnt, tc, busy} !== 10'd0) begin
            bad++;
            $display("FAIL reset_held: cnt=%0d tc=%0d busy=%0d want 0/0/0", cnt, tc, busy);
        end
        #21 rst = 1'b0;
        step();
        total++;
        if ({cnt, tc, busy} !== 10'd0) begin
            bad++;
            $display("FAIL reset_release: cnt=%0d tc=%0d busy=%0d want 0/0/0", cnt, tc, busy);
        end
    endtask

    task automatic test_one_shot();
        En = 1'b1;
        do_load(8'd5);
        total++;
        if (cnt !== 8'd5 || tc !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_load: cnt=%0d tc=%0d busy=%0d want 5/0/1", cnt, tc, busy);
        end
        for (int i = 4; i >= 0; i--) begin
            step();
            total++;
            if (cnt !== 8'(i) || tc !== (i == 0) || busy !== (i != 0)) begin
                bad++;
                $display("FAIL oneshot_count: cnt=%0d tc=%0d busy=%0d want %0d/%0d/%0d",
                         cnt, tc, busy, i, (i == 0), (i != 0));
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (cnt !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL oneshot_stay: cnt=%0d tc=%0d busy=%0d want 0/0/0", cnt, tc, busy);
            end
        end
    endtask

    task automatic test_hold();
        int n;
        En = 1'b1;
        do_load(8'd10);
        for (int i = 0; i < 4; i++) step();
        total++;
        if (cnt !== 8'd6) begin
            bad++;
            $display("FAIL hold_pre: cnt=%0d want 6", cnt);
        end
        En = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if (cnt !== 8'd6 || busy !== 1'b1 || tc !== 1'b0) begin
                bad++;
                $display("FAIL hold_frozen: cnt=%0d busy=%0d tc=%0d want 6/1/0", cnt, busy, tc);
            end
        end
        En = 1'b1;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (tc === 1'b1) break;
        end
        total++;
        if (n !== 6 || cnt !== 8'd0) begin
            bad++;
            $display("FAIL hold_resume: tc after %0d cycles cnt=%0d want 6 cycles cnt=0", n, cnt);
        end
    endtask

    task automatic test_prescale();
        int exp_cnt;
        En = 1'b1;
        do_load(8'd3);
        total++;
        if (cnt4 !== 8'd3 || busy4 !== 1'b1) begin
            bad++;
            $display("FAIL pre_load: cnt=%0d busy=%0d want 3/1", cnt4, busy4);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_cnt = 3 - k / 4;
            total++;
            if (cnt4 !== 8'(exp_cnt) || tc4 !== (k == 12)) begin
                bad++;
                $display("FAIL pre_count k=%0d: cnt=%0d tc=%0d want %0d/%0d",
                         k, cnt4, tc4, exp_cnt, (k == 12));
            end
        end
    endtask

    task automatic test_load_zero();
        do_load(8'd0);
        total++;
        if (cnt !== 8'd0 || tc !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_load: cnt=%0d tc=%0d busy=%0d want 0/1/0", cnt, tc, busy);
        end
        step();
        total++;
        if (cnt !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_after: cnt=%0d tc=%0d busy=%0d want 0/0/0", cnt, tc, busy);
        end
    endtask

    task automatic test_load_at_tc();
        En = 1'b1;
        do_load(8'd2);
        step();
        total++;
        if (cnt !== 8'd1) begin
            bad++;
            $display("FAIL ltc_pre: cnt=%0d want 1", cnt);
        end
        do_load(8'd9);
        total++;
        if (cnt !== 8'd9 || tc !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ltc_load: cnt=%0d tc=%0d busy=%0d want 9/0/1", cnt, tc, busy);
        end
        step();
        total++;
        if (cnt !== 8'd8 || tc !== 1'b0) begin
            bad++;
            $display("FAIL ltc_run: cnt=%0d tc=%0d want 8/0", cnt, tc);
        end
    endtask

    task automatic test_full_255();
        En = 1'b1;
        do_load(8'd255);
        for (int i = 254; i >= 0; i--) begin
            step();
            total++;
            if (cnt !== 8'(i) || tc !== (i == 0)) begin
                bad++;
                $display("FAIL full_count: cnt=%0d tc=%0d want %0d/%0d", cnt, tc, i, (i == 0));
            end
        end
        step();
        total++;
        if (cnt !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_nowrap: cnt=%0d tc=%0d busy=%0d want 0/0/0", cnt, tc, busy);
        end
    endtask

    task automatic test_async_reset();
        En = 1'b1;
        do_load(8'd40);
        for (int i = 0; i < 3; i++) step();
        total++;
        if (cnt !== 8'd37) begin
            bad++;
            $display("FAIL arst_pre: cnt=%0d want 37", cnt);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (cnt !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL arst_now: cnt=%0d tc=%0d busy=%0d want 0/0/0", cnt, tc, busy);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (cnt !== 8'd0 || tc !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL arst_after: cnt=%0d tc=%0d busy=%0d want 0/0/0", cnt, tc, busy);
            end
        end
    endtask

    task automatic test_auto_reload();
        int  exp_cnt;
        logic exp_tc, exp_busy;
        En = 1'b1;
        do_load(8'd3);
        for (int k = 1; k <= 9; k++) begin
            step();
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            exp_cnt  = 3 - (k % 3);
            exp_tc   = (k % 3 == 0);
            exp_busy = 1'b1;
`else
            exp_cnt  = (k < 3) ? 3 - k : 0;
            exp_tc   = (k == 3);
            exp_busy = (k < 3);
`endif
            total++;
            if (cnt !== 8'(exp_cnt) || tc !== exp_tc || busy !== exp_busy) begin
                bad++;
                $display("FAIL reload k=%0d: cnt=%0d tc=%0d busy=%0d want %0d/%0d/%0d",
                         k, cnt, tc, busy, exp_cnt, exp_tc, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_hold();
        test_prescale();
        test_load_zero();
        test_load_at_tc();
        test_full_255();
        test_async_reset();
        test_auto_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
